// File: rtl/count_block_accumulator.sv
// Accumulates N upstream 3-bit counts (dav_/rfd handshake) into a block sum and max,
// then presents each block result downstream as a dav_out_/rfd_out producer.
module count_block_accumulator #(
    parameter int unsigned N  = 8,
    parameter int unsigned SW = 6,
    parameter int unsigned CW = 4
) (
    input  logic          clock,
    input  logic          reset_,
    input  logic          dav_,
    output logic          rfd,
    input  logic [2:0]    c,
    input  logic          rfd_out,
    output logic          dav_out_,
    output logic [SW-1:0] sum,
    output logic [2:0]    max
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACK  = 3'd1,
        S_OUT1 = 3'd2,
        S_OUT2 = 3'd3
    } state_e;

    state_e          state_q, state_d;
    logic            rfd_q, rfd_d;
    logic            dav_out_q, dav_out_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic [2:0]      max_q, max_d;
    logic [SW-1:0]   acc_q, acc_d;
    logic [2:0]      mx_q, mx_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Next-state and next-output logic; sum/max only move on entry to S_OUT1.
    always_comb begin
        state_d   = state_q;
        rfd_d     = rfd_q;
        dav_out_d = dav_out_q;
        sum_d     = sum_q;
        max_d     = max_q;
        acc_d     = acc_q;
        mx_d      = mx_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                rfd_d = 1'b1;
                if (!dav_) begin
                    acc_d   = acc_q + SW'(c);
                    mx_d    = (c > mx_q) ? c : mx_q;
                    cnt_d   = cnt_q + CW'(1);
                    rfd_d   = 1'b0;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (dav_) begin
                    if (cnt_q == CW'(N)) begin
                        sum_d     = acc_q;
                        max_d     = mx_q;
                        dav_out_d = 1'b0;
                        state_d   = S_OUT1;
                    end else begin
                        rfd_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_OUT1: begin
                if (!rfd_out) begin
                    dav_out_d = 1'b1;
                    state_d   = S_OUT2;
                end
            end
            S_OUT2: begin
                if (rfd_out) begin
                    acc_d   = '0;
                    mx_d    = '0;
                    cnt_d   = '0;
                    rfd_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                rfd_d     = 1'b1;
                dav_out_d = 1'b1;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q   <= S_IDLE;
            rfd_q     <= 1'b1;
            dav_out_q <= 1'b1;
            sum_q     <= '0;
            max_q     <= '0;
            acc_q     <= '0;
            mx_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rfd_q     <= rfd_d;
            dav_out_q <= dav_out_d;
            sum_q     <= sum_d;
            max_q     <= max_d;
            acc_q     <= acc_d;
            mx_q      <= mx_d;
            cnt_q     <= cnt_d;
        end
    end

    assign rfd      = rfd_q;
    assign dav_out_ = dav_out_q;
    assign sum      = sum_q;
    assign max      = max_q;

endmodule

// File: tb/tb_count_block_accumulator.sv
// Directed bench for count_block_accumulator: a sample-list model predicts each block
// result; a monitor checks sum/max/dav_out_/rfd every cycle against it.
module tb_count_block_accumulator;
    localparam int unsigned N  = 8;
    localparam int unsigned SW = 6;
    localparam int unsigned CW = 4;

    logic          clock = 1'b0;
    logic          reset_;
    logic          dav_;
    logic          rfd;
    logic [2:0]    c;
    logic          rfd_out;
    logic          dav_out_;
    logic [SW-1:0] sum;
    logic [2:0]    max;

    count_block_accumulator #(.N(N), .SW(SW), .CW(CW)) dut (
        .clock    (clock),
        .reset_   (reset_),
        .dav_     (dav_),
        .rfd      (rfd),
        .c        (c),
        .rfd_out  (rfd_out),
        .dav_out_ (dav_out_),
        .sum      (sum),
        .max      (max)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: samples of the open block, and results of completed blocks in order.
    int part[$];
    int exp_sum[256];
    int exp_max[256];
    int wr = 0;
    int rd = 0;
    int cur_sum = 0;
    int cur_max = 0;
    logic prev_dv = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_sample(input int v);
        int s;
        int m;
        part.push_back(v);
        if (part.size() == N) begin
            s = 0;
            m = 0;
            foreach (part[i]) begin
                s += part[i];
                if (part[i] > m) m = part[i];
            end
            exp_sum[wr] = s;
            exp_max[wr] = m;
            wr++;
            part.delete();
        end
    endfunction

    task automatic send(input int v);
        int k;
        k = 0;
        while (!rfd && k < 40) begin
            @(negedge clock);
            k++;
        end
        check("send_rfd_wait", int'(rfd), 1);
        c    = 3'(v);
        dav_ = 1'b0;
        @(negedge clock);
        check("rfd_fall_on_capture", int'(rfd), 0);
        dav_ = 1'b1;
        push_sample(v);
    endtask

    task automatic wait_result();
        int k;
        k = 0;
        while (dav_out_ && k < 40) begin
            @(negedge clock);
            k++;
        end
        check("result_timeout", int'(dav_out_), 0);
    endtask

    task automatic recv(input int es, input int em);
        int k;
        wait_result();
        check("block_sum", int'(sum), es);
        check("block_max", int'(max), em);
        rfd_out = 1'b0;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!dav_out_ && k < 40);
        check("dav_out_release", int'(dav_out_), 1);
        rfd_out = 1'b1;
        @(negedge clock);
        check("rfd_after_block", int'(rfd), 1);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_ = 1'b0;
        part.delete();
        @(negedge clock);
        check("rst_rfd", int'(rfd), 1);
        check("rst_dav_out", int'(dav_out_), 1);
        check("rst_sum", int'(sum), 0);
        check("rst_max", int'(max), 0);
        reset_ = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        reset_  = 1'b0;
        dav_    = 1'b1;
        c       = 3'd0;
        rfd_out = 1'b1;

        fork
            forever begin
                @(negedge clock);
                if (!reset_) begin
                    cur_sum = 0;
                    cur_max = 0;
                    prev_dv = 1'b1;
                    rd      = wr;
                end else begin
                    if (!dav_out_ && prev_dv) begin
                        if (rd >= wr) begin
                            check("spurious_result", 1, 0);
                        end else begin
                            cur_sum = exp_sum[rd];
                            cur_max = exp_max[rd];
                            rd++;
                        end
                    end
                    check("sum_track", int'(sum), cur_sum);
                    check("max_track", int'(max), cur_max);
                    if (!dav_out_) check("rfd_stall", int'(rfd), 0);
                    prev_dv = dav_out_;
                end
            end
        join_none

        repeat (2) @(negedge clock);
        check("init_rfd", int'(rfd), 1);
        check("init_dav_out", int'(dav_out_), 1);
        check("init_sum", int'(sum), 0);
        check("init_max", int'(max), 0);
        reset_ = 1'b1;
        @(negedge clock);

        // Mixed block; no result after only 7 samples.
        send(1); send(2); send(3); send(4); send(0); send(1); send(2);
        repeat (3) @(negedge clock);
        check("no_result_after_7", int'(dav_out_), 1);
        check("rfd_after_7", int'(rfd), 1);
        send(3);
        recv(16, 4);

        // Constant blocks, including the no-wrap maximum.
        for (int i = 0; i < 8; i++) send(4);
        recv(32, 4);
        for (int i = 0; i < 8; i++) send(7);
        recv(56, 7);

        // Stall: upstream waits with c=2 while the result is held.
        for (int i = 0; i < 8; i++) send(3);
        wait_result();
        check("stall_block_sum", int'(sum), 24);
        c    = 3'd2;
        dav_ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("stall_rfd_low", int'(rfd), 0);
            check("stall_dav_out_low", int'(dav_out_), 0);
        end
        rfd_out = 1'b0;
        @(negedge clock);
        check("stall_out2", int'(dav_out_), 1);
        rfd_out = 1'b1;
        @(negedge clock);
        check("stall_rfd_back", int'(rfd), 1);
        @(negedge clock);
        check("stall_capture", int'(rfd), 0);
        dav_ = 1'b1;
        push_sample(2);
        for (int i = 0; i < 7; i++) send(1);
        recv(9, 2);

        // Reset mid-block discards the partial samples.
        send(5); send(6); send(7);
        do_reset();
        for (int i = 0; i < 8; i++) send(1);
        recv(8, 1);

        // Reset while a result is being presented.
        for (int i = 0; i < 8; i++) send(2);
        wait_result();
        check("pre_reset_sum", int'(sum), 16);
        do_reset();

        // All-zero block still produces a result; prior result held until then.
        for (int i = 0; i < 8; i++) send(5);
        recv(40, 5);
        for (int i = 0; i < 7; i++) send(0);
        repeat (2) @(negedge clock);
        check("hold_sum", int'(sum), 40);
        check("hold_max", int'(max), 5);
        send(0);
        recv(0, 0);

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
